// File: rtl/mult32x32_fast_fsm.sv
// mult32x32_fast_fsm
// Control sequencer for the 32x32 fast multiplier. Walks the 8-bit x 16-bit
// partial products of a*b in (b word outer, a byte inner) order and drives
// the arithmetic unit that accumulates them into its product register.
// Partial products that are known to be zero are skipped when ENABLE_SKIP=1:
// a[31:24]==0 drops every step with a byte index 3, b[31:16]==0 drops the
// whole upper b word.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       begin a multiplication; only looked at while idle
//   a_msb_is_0  a[31:24]==0, sampled on the start edge only
//   b_msw_is_0  b[31:16]==0, sampled on the start edge only
//   a_sel       byte of a used by the current step
//   b_sel       16-bit word of b used by the current step
//   shift_sel   byte shift of the current partial product (a_sel + 2*b_sel)
//   upd_prod    accumulate the shifted partial product this cycle
//   clr_prod    clear the product register (combinational on start)
//   busy        a partial-product step is running
//   done        single-cycle pulse; product register holds a*b
//   dbg_state   current FSM state encoding (IDLE=0, DONE=1, STEP=2)
//
// Handshake: start is a level request. It is honoured in any cycle where
// busy=0 (including the done cycle) and ignored while busy=1; nothing is
// queued. Operands must stay stable from the start cycle through done.
module mult32x32_fast_fsm #(
  parameter bit ENABLE_SKIP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_msb_is_0,
  input  logic       b_msw_is_0,
  output logic [1:0] a_sel,
  output logic       b_sel,
  output logic [2:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  // DONE is the first idle cycle after the last step; it behaves exactly
  // like IDLE for start, but raises done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] i_q, i_d;
  logic       j_q, j_d;
  logic       skip_a3_q, skip_a3_d;
  logic       skip_b1_q, skip_b1_d;
  logic       last_i, last_j;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      i_q       <= 2'd0;
      j_q       <= 1'b0;
      skip_a3_q <= 1'b0;
      skip_b1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      skip_a3_q <= skip_a3_d;
      skip_b1_q <= skip_b1_d;
    end
  end

  // Byte index 2 is the last one when the top byte of a is zero; word 0 is
  // the last one when the upper word of b is zero.
  assign last_i = (i_q == 2'd3) || (skip_a3_q && (i_q == 2'd2));
  assign last_j = j_q || skip_b1_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    skip_a3_d = skip_a3_q;
    skip_b1_d = skip_b1_q;
    clr_prod  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          clr_prod  = 1'b1;
          skip_a3_d = ENABLE_SKIP & a_msb_is_0;
          skip_b1_d = ENABLE_SKIP & b_msw_is_0;
          i_d       = 2'd0;
          j_d       = 1'b0;
          state_d   = S_STEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (last_i) begin
          i_d = 2'd0;
          if (last_j) begin
            // Indices return to 0 so the selects read 0 while idle.
            j_d     = 1'b0;
            state_d = S_DONE;
          end else begin
            j_d = 1'b1;
          end
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        i_d     = 2'd0;
        j_d     = 1'b0;
      end
    endcase
  end

  // Moore outputs straight from the state and index registers.
  assign busy      = (state_q == S_STEP);
  assign upd_prod  = busy;
  assign done      = (state_q == S_DONE);
  assign a_sel     = i_q;
  assign b_sel     = j_q;
  assign shift_sel = {1'b0, i_q} + {1'b0, j_q, 1'b0};
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
module tb_mult32x32_fast_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start1 = 1'b0;
  logic        start0 = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        use0 = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic a_msb_is_0, b_msw_is_0;
  assign a_msb_is_0 = (a[31:24] == 8'd0);
  assign b_msw_is_0 = (b[31:16] == 16'd0);

  // skip-enabled instance
  logic [1:0] a_sel1, st1;
  logic       b_sel1, upd1, clr1, busy1, done1;
  logic [2:0] sh1;
  // skip-disabled instance
  logic [1:0] a_sel0, st0;
  logic       b_sel0, upd0, clr0, busy0, done0;
  logic [2:0] sh0;

  mult32x32_fast_fsm #(.ENABLE_SKIP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a_msb_is_0(a_msb_is_0), .b_msw_is_0(b_msw_is_0),
    .a_sel(a_sel1), .b_sel(b_sel1), .shift_sel(sh1), .upd_prod(upd1),
    .clr_prod(clr1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  mult32x32_fast_fsm #(.ENABLE_SKIP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .a_msb_is_0(a_msb_is_0), .b_msw_is_0(b_msw_is_0),
    .a_sel(a_sel0), .b_sel(b_sel0), .shift_sel(sh0), .upd_prod(upd0),
    .clr_prod(clr0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  // Behavioural arithmetic unit: selected byte of a times selected word of
  // b, shifted left by shift_sel bytes, accumulated into a 64-bit product.
  function automatic logic [63:0] pp(input logic [31:0] x, input logic [31:0] y,
                                     input logic [1:0] as, input logic bs,
                                     input logic [2:0] sh);
    logic [7:0]  ab;
    logic [15:0] bw;
    ab = x[8*as +: 8];
    bw = bs ? y[31:16] : y[15:0];
    return (64'(ab) * 64'(bw)) << (8 * sh);
  endfunction

  logic [63:0] prod1 = 64'd0;
  logic [63:0] prod0 = 64'd0;

  always_ff @(posedge clk) begin
    if (clr1)      prod1 <= 64'd0;
    else if (upd1) prod1 <= prod1 + pp(a, b, a_sel1, b_sel1, sh1);
    if (clr0)      prod0 <= 64'd0;
    else if (upd0) prod0 <= prod0 + pp(a, b, a_sel0, b_sel0, sh0);
  end

  // Observation mux: use0 selects the skip-disabled instance.
  logic [1:0]  m_asel;
  logic        m_bsel, m_upd, m_clr, m_busy, m_done;
  logic [2:0]  m_sh;
  logic [63:0] m_prod;
  assign m_asel = use0 ? a_sel0 : a_sel1;
  assign m_bsel = use0 ? b_sel0 : b_sel1;
  assign m_upd  = use0 ? upd0   : upd1;
  assign m_clr  = use0 ? clr0   : clr1;
  assign m_busy = use0 ? busy0  : busy1;
  assign m_done = use0 ? done0  : done1;
  assign m_sh   = use0 ? sh0    : sh1;
  assign m_prod = use0 ? prod0  : prod1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         steps;
  int         done_cyc;
  logic       seen_a3;
  logic       seen_b1;
  logic [2:0] shq[$];

  // Called at posedge+1 in an idle cycle. Leaves at posedge+1 of the cycle
  // after done.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int n,
                        input logic [63:0] exp_prod, input string tag);
    a = av;
    b = bv;
    if (use0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    chk({tag, " clr on start"}, 64'(m_clr), 64'd1);
    chk({tag, " idle before"}, {62'd0, m_busy, m_done}, 64'd0);
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    steps = 0;
    done_cyc = 0;
    seen_a3 = 1'b0;
    seen_b1 = 1'b0;
    shq.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_upd) begin
        steps++;
        shq.push_back(m_sh);
        if (m_asel == 2'd3) seen_a3 = 1'b1;
        if (m_bsel) seen_b1 = 1'b1;
      end
      if (m_done) begin
        done_cyc = k;
        chk({tag, " product"}, m_prod, exp_prod);
        break;
      end
    end
    chk({tag, " steps"}, 64'(steps), 64'(n));
    chk({tag, " done cycle"}, 64'(done_cyc), 64'(n + 1));
    @(posedge clk);
    #1;
  endtask

  logic [2:0] exp_sh[8];
  int         done_seen;

  initial begin
    exp_sh[0] = 3'd0; exp_sh[1] = 3'd1; exp_sh[2] = 3'd2; exp_sh[3] = 3'd3;
    exp_sh[4] = 3'd2; exp_sh[5] = 3'd3; exp_sh[6] = 3'd4; exp_sh[7] = 3'd5;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset a_sel", 64'(a_sel1), 64'd0);
    chk("reset b_sel/shift", {60'd0, b_sel1, sh1}, 64'd0);
    chk("reset upd/clr/busy/done", {60'd0, upd1, clr1, busy1, done1}, 64'd0);
    chk("reset state", 64'(st1), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle after reset", {60'd0, upd1, clr1, busy1, done1}, 64'd0);

    // 1: full 8 steps
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 64'hFFFF_FFFE_0000_0001, "s1");
    for (int k = 0; k < 8; k++)
      chk($sformatf("s1 shift[%0d]", k), 64'(shq.size() > k ? shq[k] : 3'd7), 64'(exp_sh[k]));
    chk("s1 done one pulse", 64'(done1), 64'd0);

    // 2: top byte of a zero
    run_op(32'h00FF_FFFF, 32'hFFFF_FFFF, 6, 64'h00FF_FFFE_FF00_0001, "s2");
    chk("s2 a_sel never 3", 64'(seen_a3), 64'd0);
    chk("s2 b_sel used", 64'(seen_b1), 64'd1);

    // 3: upper word of b zero
    run_op(32'hFFFF_FFFF, 32'h0000_FFFF, 4, 64'h0000_FFFE_FFFF_0001, "s3");
    chk("s3 b_sel stays 0", 64'(seen_b1), 64'd0);
    chk("s3 a_sel reaches 3", 64'(seen_a3), 64'd1);

    // 4: both skips, then skip disabled
    run_op(32'd3, 32'd5, 3, 64'h0F, "s4");
    use0 = 1'b1;
    run_op(32'd3, 32'd5, 8, 64'h0F, "s4 noskip");
    use0 = 1'b0;

    // 5: reset during the 4th step of a full operation
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("s5 in step 4", {61'd0, upd1, sh1}, {61'd1, 3'd3});
    #1;
    reset = 1'b0;
    #1;
    chk("s5 async outputs 0", {58'd0, a_sel1, b_sel1, upd1, clr1, busy1, done1},
        64'd0);
    chk("s5 shift 0", 64'(sh1), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done1 || busy1) done_seen++;
    end
    chk("s5 no done after reset", 64'(done_seen), 64'd0);
    @(posedge clk);
    #1;
    run_op(32'd2, 32'd3, 3, 64'd6, "s5 after reset");

    // 6: start held high, back-to-back operations
    a = 32'h10;
    b = 32'h10;
    start1 = 1'b1;
    @(negedge clk);
    chk("s6 first clr", 64'(clr1), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("s6 op1 step %0d busy/clr", k), {62'd0, busy1, clr1}, 64'd2);
    end
    @(negedge clk);
    chk("s6 op1 done+clr", {62'd0, done1, clr1}, 64'd3);
    chk("s6 op1 product", prod1, 64'h100);
    a = 32'd7;
    b = 32'd9;
    for (int k = 5; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("s6 op2 step %0d busy/clr", k), {62'd0, busy1, clr1}, 64'd2);
    end
    @(negedge clk);
    chk("s6 op2 done+clr", {62'd0, done1, clr1}, 64'd3);
    chk("s6 op2 product", prod1, 64'h3F);
    start1 = 1'b0;
    @(posedge clk);
    #1;
    chk("s6 idle at end", {62'd0, busy1, done1}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
